// File: rtl/seq_mul_add_pkg.sv
// Shared types and sizing helpers for the sequential multiply-accumulate unit.
package seq_mul_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_2n.sv
// W-bit adder/subtractor: y = a + b, or a - b computed as a + ~b + 1; carry-out dropped.
module addsub_2n #(
  parameter int W = 128
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  logic [W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign y     = a + b_eff + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/seq_mul_add.sv
// Shift-and-add multiply-accumulate, z = a*b + addend mod 2^(2N), one multiplier bit per clock.
// IDLE: waiting for a request | RUN: one multiplier bit per cycle | DONE: z valid, awaiting out_ready
module seq_mul_add
  import seq_mul_add_pkg::*;
#(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [2*N-1:0] c,
  input  logic           signed_mode,
  input  logic           acc_sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] z
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           mode;
  logic [2*N-1:0] last_z;
  logic [2*N-1:0] sum;
  logic           step_sub;

  // In signed mode the multiplier MSB carries weight -2^(N-1), so the last step subtracts.
  assign step_sub = mode && (cnt == LAST);

  addsub_2n #(.W(2 * N)) u_addsub (
    .a   (acc),
    .b   (mcand),
    .sub (step_sub),
    .y   (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      mode   <= 1'b0;
      last_z <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= acc_sel ? last_z : c;
            mcand  <= {{N{signed_mode & a[N-1]}}, a};
            mplier <= b;
            cnt    <= '0;
            mode   <= signed_mode;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            last_z <= acc;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign z         = acc;

endmodule

// File: tb/tb_seq_mul_add.sv
// Directed and randomized checks of seq_mul_add (N = 8) against an arithmetic reference model.
module tb_seq_mul_add;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] c;
  logic           signed_mode;
  logic           acc_sel;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] z;

  int             n_vec = 0;
  int             n_err = 0;
  logic [2*N-1:0] model_last_z = '0;
  logic [2*N-1:0] zr;

  always #5 clk = ~clk;

  seq_mul_add #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .c           (c),
    .signed_mode (signed_mode),
    .acc_sel     (acc_sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .z           (z)
  );

  function automatic logic [15:0] ref_mac(input logic [7:0] x, input logic [7:0] y,
                                          input logic [15:0] ad, input logic s);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y)) + longint'($signed(ad));
    else   p = longint'({56'd0, x}) * longint'({56'd0, y}) + longint'({48'd0, ad});
    return p[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle. hold = cycles out_ready stays low once z is valid;
  // spur = also present a competing request during the hold.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [15:0] tc, input logic ts, input logic tacc,
                        input int hold, input logic spur, output logic [15:0] zo);
    logic [15:0] exp;
    int lat;
    exp = ref_mac(ta, tb, tacc ? model_last_z : tc, ts);
    check({tag, " in_ready_before"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; c = tc; signed_mode = ts; acc_sel = tacc;
    in_valid = 1'b1; out_ready = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        a = $urandom; b = $urandom; c = $urandom;
        signed_mode = $urandom; acc_sel = $urandom;
      end
    end while (!out_valid && lat < 40);
    check({tag, " latency"}, lat, N + 1);
    check({tag, " z"}, {16'd0, z}, {16'd0, exp});
    zo = z;
    for (int i = 0; i < hold; i++) begin
      if (spur) begin
        in_valid = 1'b1; a = 8'h55; b = 8'h33; c = 16'h1234; acc_sel = 1'b0;
      end
      @(posedge clk); #1;
      check({tag, " hold z"}, {16'd0, z}, {16'd0, exp});
      check({tag, " hold ready/valid"}, {30'd0, in_ready, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    model_last_z = exp;
    check({tag, " back to idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0;
    signed_mode = 1'b0; acc_sel = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset z", {16'd0, z}, 32'd0);

    run_op("unsigned", 8'd200, 8'd150, 16'h03E8, 1'b0, 1'b0, 0, 1'b0, zr);
    check("unsigned const", {16'd0, zr}, 32'h7918);
    run_op("accumulate", 8'd1, 8'd1, 16'hAAAA, 1'b0, 1'b1, 0, 1'b0, zr);
    check("accumulate const", {16'd0, zr}, 32'h7919);
    run_op("signed1", 8'hFD, 8'h05, 16'h0010, 1'b1, 1'b0, 0, 1'b0, zr);
    check("signed1 const", {16'd0, zr}, 32'h0001);
    run_op("signed2", 8'h80, 8'h80, 16'h0000, 1'b1, 1'b0, 1, 1'b0, zr);
    check("signed2 const", {16'd0, zr}, 32'h4000);
    run_op("wrap", 8'hFF, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0, zr);
    check("wrap const", {16'd0, zr}, 32'hFE00);
    run_op("backpressure", 8'h12, 8'h34, 16'h0100, 1'b0, 1'b0, 5, 1'b1, zr);

    // Abort an operation once cnt has reached 3.
    a = 8'h77; b = 8'h99; c = 16'h4321; signed_mode = 1'b0; acc_sel = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("midrun reset ready/valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("midrun reset z", {16'd0, z}, 32'd0);
    model_last_z = '0;
    run_op("after reset acc", 8'd2, 8'd3, 16'hBEEF, 1'b0, 1'b1, 0, 1'b0, zr);
    check("after reset acc const", {16'd0, zr}, 32'h0006);

    for (int k = 0; k < 20; k++) begin
      run_op("random", 8'($urandom), 8'($urandom), 16'($urandom), 1'($urandom),
             1'($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'($urandom), zr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
